// File: rtl/acc_drain.sv
// -----------------------------------------------------------------------------
// acc_drain
// Read-side sequencer for the double-buffered accumulator memory. A launch
// pulse captures a base address and a length. The block then walks the
// accumulator read port and streams the 64-bit entries downstream on a
// valid/ready interface. The accumulator has a 1-cycle registered read
// latency, so a small output FIFO holds returning data until it is accepted.
// Reads are only issued when a FIFO slot is guaranteed to be free.
//
// The controller must keep acc_buf_sel stable while busy=1.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         launch pulse, only honoured in IDLE
//   base_addr     first accumulator address (captured on start)
//   length        number of entries (captured on start, saturates at 2**ADDR_W)
//   busy          high while reading or draining
//   done          one-cycle completion pulse
//   acc_rd_en     accumulator read enable
//   acc_rd_addr   accumulator read address (holds the last issued address)
//   acc_rd_data   accumulator read data, valid one cycle after acc_rd_en
//   out_valid     output beat valid (FIFO not empty)
//   out_ready     output beat accepted
//   out_data      output beat data (FIFO head)
//   out_last      marks the final beat of the transfer
// -----------------------------------------------------------------------------
module acc_drain #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [DATA_W-1:0] acc_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  base_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   issue_cnt_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic               inflight_r;
    logic               inflight_last_r;

    logic [DATA_W-1:0]  fifo_data_r [FIFO_DEPTH];
    logic               fifo_last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               pop_s;
    logic               push_s;
    logic               space_ok_s;
    logic               issue_s;
    logic               last_issue_s;
    logic               drain_empty_s;
    logic [ADDR_W-1:0]  next_addr_s;
    logic [LEN_W-1:0]   len_sat_s;

    // Circular pointer advance; also correct for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Handshake, issue-credit and address datapath.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        space_ok_s   = 1'b0;
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        next_addr_s  = '0;
        len_sat_s    = '0;

        pop_s  = (count_r != CNT_W'(0)) && out_ready;
        push_s = inflight_r;
        // count + inflight - pop < DEPTH, rearranged so nothing goes negative.
        space_ok_s = ({1'b0, count_r} + SUM_W'(inflight_r))
                     < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop_s));
        issue_s      = (state_r == ST_READ) && space_ok_s;
        last_issue_s = issue_s && (issue_cnt_r == (len_r - LEN_W'(1)));
        next_addr_s  = base_r + issue_cnt_r[ADDR_W-1:0];
        if (length > MAX_LEN) begin
            len_sat_s = MAX_LEN;
        end else begin
            len_sat_s = length;
        end
    end

    // Drain completes in the cycle the final beat is handed off, so done
    // lands in the cycle right after the final handshake.
    assign drain_empty_s = !inflight_r && (count_r == CNT_W'(pop_s));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (length == LEN_W'(0)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (last_issue_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (drain_empty_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, transfer parameters, issue counter and in-flight tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            base_r          <= '0;
            len_r           <= '0;
            issue_cnt_r     <= '0;
            rd_addr_r       <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
            if ((state_r == ST_IDLE) && start) begin
                base_r      <= base_addr;
                len_r       <= len_sat_s;
                issue_cnt_r <= '0;
            end else if (issue_s) begin
                issue_cnt_r <= issue_cnt_r + LEN_W'(1);
                rd_addr_r   <= next_addr_s;
            end
        end
    end

    // FIFO storage; contents need no reset because count_r qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= acc_rd_data;
            fifo_last_r[wr_ptr_r] <= inflight_last_r;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign busy        = (state_r == ST_READ) || (state_r == ST_DRAIN);
    assign done        = (state_r == ST_DONE);
    assign acc_rd_en   = issue_s;
    assign acc_rd_addr = issue_s ? next_addr_s : rd_addr_r;
    assign out_valid   = (count_r != CNT_W'(0));
    // Head data is masked while empty so the outputs read 0 after reset.
    assign out_data    = out_valid ? fifo_data_r[rd_ptr_r] : '0;
    assign out_last    = out_valid & fifo_last_r[rd_ptr_r];

endmodule
